mont_domain_enter: RTL and testbench

// - Converts an operand into the Montgomery domain for the RSA datapath: Y = X * 2^WIDTH mod N.
// - This is the inverse of the Montgomery multiply step, which divides by 2^WIDTH. It runs once per operand before exponentiation.
// - It is a sequential shift-and-subtract engine with a start/done handshake.

---
 rtl/mont_pkg.sv | 15 +
 rtl/mont_domain_enter_if.sv | 26 ++
 rtl/mont_dbl_step.sv | 45 ++++
 rtl/mont_domain_enter.sv | 121 ++++++++++++
 tb/tb_mont_domain_enter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery datapath blocks. These are the default
// operand width, the iteration counter width and the engine state encoding.
package mont_pkg;

  localparam int MONT_WIDTH = 256;
  localparam int MONT_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mont_domain_enter_if.sv
// Request/response bundle for mont_domain_enter.
//
// Handshake: start is a request, and it is taken only while busy is low. That
// means the engine is in IDLE or DONE. X and N are captured on that same
// edge and may change afterwards. busy is high while an operation is in
// flight. done pulses for exactly one cycle, and err is valid in that cycle.
// Y and err then hold until the next operation completes. If start is high
// while done is high, a new operation begins in the very next cycle.
// The state signal mirrors the engine FSM for observation only.
interface mont_domain_enter_if
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] N;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] Y;
  state_t           state;

  modport master (output start, X, N, input busy, done, err, Y, state);
  modport slave  (input start, X, N, output busy, done, err, Y, state);
endinterface

// File: rtl/mont_dbl_step.sv
// One combinational reduction step: t_next = (R * t) mod N, given 0 <= t < N.
// R is 2 by default. R is 4 when RADIX4_EN is defined, and in that build the
// caller supplies the precomputed 2N and 3N.
module mont_dbl_step
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH
) (
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] n_i,
`ifdef RADIX4_EN
  input  logic [WIDTH:0]   n2_i,
  input  logic [WIDTH+1:0] n3_i,
`endif
  output logic [WIDTH-1:0] t_next_o
);

`ifdef RADIX4_EN
  logic [WIDTH+1:0] u;
  logic [WIDTH+2:0] d1, d2, d3;

  // u = 4t < 4N. Pick the largest q with q*N <= u, using sign bits of trial subtractions
  always_comb begin
    u        = {t_i, 2'b00};
    d1       = {1'b0, u} - {3'b000, n_i};
    d2       = {1'b0, u} - {2'b00, n2_i};
    d3       = {1'b0, u} - {1'b0, n3_i};
    t_next_o = u[WIDTH-1:0];
    if (!d3[WIDTH+2])      t_next_o = d3[WIDTH-1:0];
    else if (!d2[WIDTH+2]) t_next_o = d2[WIDTH-1:0];
    else if (!d1[WIDTH+2]) t_next_o = d1[WIDTH-1:0];
  end
`else
  logic [WIDTH:0]   u;
  logic [WIDTH+1:0] d;

  // u = 2t < 2N, so at most one subtraction of N brings it back below N
  always_comb begin
    u        = {t_i, 1'b0};
    d        = {1'b0, u} - {2'b00, n_i};
    t_next_o = d[WIDTH+1] ? u[WIDTH-1:0] : d[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/mont_domain_enter.sv
// Montgomery domain entry: Y = X * 2^WIDTH mod N. The engine performs a
// sequence of modular doublings. The optional RADIX4_EN macro selects the
// radix-4 step, which does two doublings per RUN cycle.
module mont_domain_enter
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH,
  parameter int CNT_W = MONT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,  // active-high asynchronous reset
  mont_domain_enter_if.slave bus
);

`ifdef RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, n_q, t_q, y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             accept;
  logic             n_legal;
  logic [WIDTH+1:0] ld_diff;
  logic [WIDTH-1:0] ld_t;
  logic [WIDTH-1:0] t_next;
`ifdef RADIX4_EN
  logic [WIDTH:0]   n2_q;
  logic [WIDTH+1:0] n3_q;
`endif

  assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  // An odd modulus greater than one is required for the doubling loop
  assign n_legal = n_q[0] && (n_q != WIDTH'(1));
  // Initial reduction of X into [0, N); exact as long as X < 2N
  assign ld_diff = {2'b00, x_q} - {2'b00, n_q};
  assign ld_t    = ld_diff[WIDTH+1] ? x_q : ld_diff[WIDTH-1:0];

  mont_dbl_step #(.WIDTH(WIDTH)) u_step (
    .t_i      (t_q),
    .n_i      (n_q),
`ifdef RADIX4_EN
    .n2_i     (n2_q),
    .n3_i     (n3_q),
`endif
    .t_next_o (t_next)
  );

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an illegal modulus or N==1 skips RUN entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: state_d = n_legal ? RUN : DONE;
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: state_d = bus.start ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands, reduce, iterate, and publish the result on entry to DONE
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x_q   <= '0;
      n_q   <= '0;
      t_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef RADIX4_EN
      n2_q  <= '0;
      n3_q  <= '0;
`endif
    end else begin
      if (accept) begin
        x_q <= bus.X;
        n_q <= bus.N;
      end
      case (state_q)
        LOAD: begin
          t_q   <= ld_t;
          cnt_q <= '0;
`ifdef RADIX4_EN
          n2_q  <= {n_q, 1'b0};
          n3_q  <= {1'b0, n_q, 1'b0} + {2'b00, n_q};
`endif
          if (!n_legal) begin
            y_q   <= '0;
            err_q <= ~n_q[0];  // even (including zero) is an error, N==1 is not
          end
        end
        RUN: begin
          t_q   <= t_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            y_q   <= t_next;
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q == LOAD) || (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.err   = err_q;
  assign bus.Y     = y_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_mont_domain_enter.sv
// Bench for mont_domain_enter. It drives random and directed operands. A
// scoreboard queue holds the expected Y/err/latency of every accepted request.
// A monitor checks each done pulse against the head of that queue.
module tb_mont_domain_enter;
  import mont_pkg::*;

  localparam int W = MONT_WIDTH;
`ifdef RADIX4_EN
  localparam int LAT_RUN = W / 2 + 2;
`else
  localparam int LAT_RUN = W + 2;
`endif
  localparam int LAT_SHORT = 2;

  typedef struct packed {
    logic [W-1:0] y;
    logic         err;
    logic [31:0]  t0;
    logic [31:0]  lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  cyc;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_y;
  logic [W-1:0] p_mod;
  int           checks;
  int           errors;

  mont_domain_enter_if #(.WIDTH(W)) bus ();

  mont_domain_enter #(.WIDTH(W), .CNT_W(MONT_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: the Montgomery form by definition, (X * 2^W) mod N, with the error rules
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] n,
                       output logic [W-1:0] y, output logic err, output logic [31:0] lat);
    logic [2*W-1:0] wide;
    logic [2*W-1:0] nw;
    if (n[0] == 1'b0) begin
      y = '0; err = 1'b1; lat = LAT_SHORT;
    end else if (n == W'(1)) begin
      y = '0; err = 1'b0; lat = LAT_SHORT;
    end else begin
      wide = {x, {W{1'b0}}};
      nw   = {{W{1'b0}}, n};
      wide = wide % nw;
      y    = wide[W-1:0];
      err  = 1'b0;
      lat  = LAT_RUN;
    end
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] n);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("y_hold", bus.Y, last_y);
    model(x, n, e.y, e.err, e.lat);
    e.t0 = cyc;
    bus.start = 1'b1;
    bus.X     = x;
    bus.N     = n;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.X     = rand_w();
    bus.N     = rand_w();
    chk("busy_in_load", W'(bus.busy), W'(1));
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: %0d responses still pending after %0d cycles", exp_q.size(), bound);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n == 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done at cycle %0d with no request outstanding", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("y", bus.Y, mon_e.y);
        chk("err", W'(bus.err), W'(mon_e.err));
        chk("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
        chk("busy_at_done", W'(bus.busy), W'(0));
        last_y = mon_e.y;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] x, n;
    exp_t         e;
    logic [31:0]  t0;
    checks    = 0;
    errors    = 0;
    last_y    = '0;
    bus.start = 1'b0;
    bus.X     = '0;
    bus.N     = '0;
    p_mod     = {W{1'b1}} - W'(188);  // 2^W - 189

    // Reset values
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_err", W'(bus.err), W'(0));
    chk("rst_y", bus.Y, '0);
    chk("rst_state", W'(bus.state), W'(IDLE));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Directed operands
    issue(W'(1), p_mod);  wait_idle(600);
    issue('0, p_mod);     wait_idle(600);
    issue(p_mod - W'(1), p_mod); wait_idle(600);
    issue(W'(5), W'(1));  wait_idle(600);
    issue(W'(7), W'(16)); wait_idle(600);
    issue(W'(3), '0);     wait_idle(600);
    issue(W'(2), p_mod);  wait_idle(600);

    // start held for 300 cycles: a new run begins in each done cycle that sees start high
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b1;
    bus.X     = W'(1);
    bus.N     = p_mod;
    for (int k = 0; k * LAT_RUN < 300; k++) begin
      model(W'(1), p_mod, e.y, e.err, e.lat);
      e.t0 = t0 + 32'(k * LAT_RUN);
      exp_q.push_back(e);
    end
    repeat (300) @(negedge clk);
    bus.start = 1'b0;
    wait_idle(800);

    // Reset in the middle of a run clears outputs immediately
    issue(W'(1), p_mod);
    repeat (99) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", W'(bus.busy), W'(0));
    chk("midrst_done", W'(bus.done), W'(0));
    chk("midrst_y", bus.Y, '0);
    chk("midrst_state", W'(bus.state), W'(IDLE));
    exp_q.delete();
    last_y = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    issue(W'(1), p_mod); wait_idle(600);

    // Random odd moduli of assorted magnitudes, X < N
    for (int i = 0; i < 110; i++) begin
      n = rand_w() >> $urandom_range(0, 250);
      n[0] = 1'b1;
      if (n == W'(1)) n = W'(3);
      x = rand_w() % n;
      issue(x, n);
      wait_idle(600);
    end

    // A few random illegal / trivial moduli mixed in
    for (int i = 0; i < 4; i++) begin
      n = rand_w();
      n[0] = 1'b0;
      issue(rand_w(), n);
      wait_idle(600);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
